// File: rtl/rv_defs_pkg.sv
// +----------------------------------------------------------------------+
// | rv_defs_pkg : shared RISC-V opcodes, fetch constants and FSM states  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package rv_defs_pkg;

  localparam logic [6:0]  OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0]  OPC_ITYPE  = 7'b0010011;
  localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;
  localparam logic [31:0] INSTR_HALT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP    = 32'd4;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/instruction_memory.sv
// +----------------------------------------------------------------------+
// | instruction_memory : IMEM_WORDS x 32 array, combinational word read  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module instruction_memory #(
  parameter int IMEM_WORDS = 256,
  parameter int AW         = $clog2(IMEM_WORDS)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] memory [IMEM_WORDS];

  // Write port exists for loading; the fetch stage ties it off.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      memory[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = memory[i_raddr];

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// +----------------------------------------------------------------------+
// | instruction_fetch : PC, IDLE/RUN/HALT sequencing, ROM fetch, counters|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module instruction_fetch
  import rv_defs_pkg::*;
#(
  parameter int          IMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          CNT_WIDTH  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 stall_i,
  output logic [31:0]          pc_o,
  output logic [31:0]          instr_o,
  output logic [6:0]           opcode_o,
  output logic                 valid_o,
  output logic                 halted_o,
  output logic [CNT_WIDTH-1:0] cycle_cnt_o,
  output logic [CNT_WIDTH-1:0] retired_cnt_o
);

  localparam int          AW      = $clog2(IMEM_WORDS);
  localparam logic [31:0] LAST_PC = 32'(IMEM_WORDS * 4 - 4);

  localparam logic [1:0] ST_IDLE = FS_IDLE;
  localparam logic [1:0] ST_RUN  = FS_RUN;
  localparam logic [1:0] ST_HALT = FS_HALT;

  logic [1:0]           r_state;
  logic [31:0]          r_pc;
  logic [CNT_WIDTH-1:0] r_cycle_cnt;
  logic [CNT_WIDTH-1:0] r_retired_cnt;

  logic [31:0]          w_rdata;
  logic                 w_valid;
  logic                 w_zero_word;
  logic                 w_last_word;
  logic [CNT_WIDTH-1:0] w_cycle_inc;
  logic [CNT_WIDTH-1:0] w_retired_inc;

  instruction_memory #(
    .IMEM_WORDS (IMEM_WORDS),
    .AW         (AW)
  ) u_imem (
    .i_clk   (clk_i),
    .i_we    (1'b0),
    .i_waddr ({AW{1'b0}}),
    .i_wdata (32'h0),
    .i_raddr (r_pc[AW+1:2]),
    .o_rdata (w_rdata)
  );

  assign w_valid     = (r_state == ST_RUN);
  assign w_zero_word = w_valid && (w_rdata == INSTR_HALT);
  assign w_last_word = (r_pc == LAST_PC);

  // Saturating increments: counters stick at all-ones rather than wrapping.
  assign w_cycle_inc   = (&r_cycle_cnt)   ? r_cycle_cnt   : r_cycle_cnt   + CNT_WIDTH'(1);
  assign w_retired_inc = (&r_retired_cnt) ? r_retired_cnt : r_retired_cnt + CNT_WIDTH'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_cycle_cnt   <= '0;
      r_retired_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_cycle_cnt <= w_cycle_inc;
          if (w_zero_word) begin
            r_state <= ST_HALT;
          end else if (!stall_i) begin
            r_retired_cnt <= w_retired_inc;
            // The last word retires but the PC parks on it instead of wrapping.
            if (w_last_word) begin
              r_state <= ST_HALT;
            end else begin
              r_pc <= r_pc + PC_STEP;
            end
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign pc_o          = r_pc;
  assign instr_o       = w_valid ? w_rdata : INSTR_NOP;
  assign opcode_o      = instr_o[6:0];
  assign valid_o       = w_valid;
  assign halted_o      = (r_state == ST_HALT);
  assign cycle_cnt_o   = r_cycle_cnt;
  assign retired_cnt_o = r_retired_cnt;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// +----------------------------------------------------------------------+
// | tb_instruction_fetch : directed self-checking bench, 256- and 4-word |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_instruction_fetch;
  import rv_defs_pkg::*;

  localparam logic [31:0] I_ADDI = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] I_ADD  = 32'h0020_81B3;  // add  x3,x1,x2
  localparam logic [31:0] I_SUB  = 32'h4020_8233;  // sub  x4,x1,x2

  logic        clk = 1'b0;
  logic        rst, start, stall;
  logic [31:0] pc, instr;
  logic [6:0]  opcode;
  logic        valid, halted;
  logic [31:0] cyc, ret;

  logic        rst4, start4, stall4;
  logic [31:0] pc4, instr4;
  logic [6:0]  opcode4;
  logic        valid4, halted4;
  logic [2:0]  cyc4, ret4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instruction_fetch #(
    .IMEM_WORDS (256),
    .RESET_PC   (32'h0),
    .CNT_WIDTH  (32)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .stall_i       (stall),
    .pc_o          (pc),
    .instr_o       (instr),
    .opcode_o      (opcode),
    .valid_o       (valid),
    .halted_o      (halted),
    .cycle_cnt_o   (cyc),
    .retired_cnt_o (ret)
  );

  instruction_fetch #(
    .IMEM_WORDS (4),
    .RESET_PC   (32'h0),
    .CNT_WIDTH  (3)
  ) dut4 (
    .clk_i         (clk),
    .rst_i         (rst4),
    .start_i       (start4),
    .stall_i       (stall4),
    .pc_o          (pc4),
    .instr_o       (instr4),
    .opcode_o      (opcode4),
    .valid_o       (valid4),
    .halted_o      (halted4),
    .cycle_cnt_o   (cyc4),
    .retired_cnt_o (ret4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    rst4 = 1'b1; start4 = 1'b0; stall4 = 1'b0;
    for (int i = 0; i < 256; i++) dut.u_imem.memory[i] = 32'h0;
    dut.u_imem.memory[0] = I_ADDI;
    dut.u_imem.memory[1] = I_ADD;
    dut.u_imem.memory[2] = I_SUB;
    dut4.u_imem.memory[0] = I_ADDI;
    dut4.u_imem.memory[1] = I_ADD;
    dut4.u_imem.memory[2] = I_SUB;
    dut4.u_imem.memory[3] = I_ADDI;

    // Reset state
    step();
    rst = 1'b0; rst4 = 1'b0;
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_instr", instr, INSTR_NOP);
    chk("rst_opcode", {25'b0, opcode}, {25'b0, OPC_ITYPE});
    chk("rst_cyc", cyc, 32'd0);
    chk("rst_ret", ret, 32'd0);

    // Idle with start low
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_valid", {31'b0, valid}, 32'd0);
      chk("idle_pc", pc, 32'd0);
      chk("idle_instr", instr, 32'h13);
      chk("idle_cyc", cyc, 32'd0);
      chk("idle_ret", ret, 32'd0);
    end

    // Basic program, halts on zero word at pc 12
    start = 1'b1;
    step();
    start = 1'b0;
    chk("run_valid0", {31'b0, valid}, 32'd1);
    chk("run_pc0", pc, 32'd0);
    chk("run_instr0", instr, I_ADDI);
    chk("run_opc0", {25'b0, opcode}, {25'b0, OPC_ITYPE});
    step();
    chk("run_pc4", pc, 32'd4);
    chk("run_instr4", instr, I_ADD);
    chk("run_opc4", {25'b0, opcode}, {25'b0, OPC_RTYPE});
    chk("run_cyc1", cyc, 32'd1);
    chk("run_ret1", ret, 32'd1);
    step();
    chk("run_pc8", pc, 32'd8);
    chk("run_instr8", instr, I_SUB);
    step();
    chk("run_pc12", pc, 32'd12);
    chk("run_instr12", instr, 32'h0);
    chk("run_valid12", {31'b0, valid}, 32'd1);
    step();
    chk("halt_halted", {31'b0, halted}, 32'd1);
    chk("halt_valid", {31'b0, valid}, 32'd0);
    chk("halt_pc", pc, 32'd12);
    chk("halt_instr", instr, INSTR_NOP);
    chk("halt_ret", ret, 32'd3);
    chk("halt_cyc", cyc, 32'd4);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("halt_sticky", {31'b0, halted}, 32'd1);
    chk("halt_sticky_pc", pc, 32'd12);

    // Reset mid-run at pc 8, then restart
    rst = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("mid_pc8", pc, 32'd8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", {31'b0, valid}, 32'd0);
    chk("mid_rst_pc", pc, 32'd0);
    chk("mid_rst_cyc", cyc, 32'd0);
    chk("mid_rst_ret", ret, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_pc", pc, 32'd0);
    chk("restart_instr", instr, I_ADDI);

    // Zero word fetched while stalled
    step(); step(); step();
    chk("zs_pc12", pc, 32'd12);
    chk("zs_ret_before", ret, 32'd3);
    stall = 1'b1;
    step();
    stall = 1'b0;
    chk("zs_halted", {31'b0, halted}, 32'd1);
    chk("zs_pc", pc, 32'd12);
    chk("zs_ret", ret, 32'd3);
    chk("zs_cyc", cyc, 32'd4);

    // 4-word memory: stall twice at pc 4, end-of-memory halt
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    chk("m4_pc0", pc4, 32'd0);
    step();
    chk("m4_pc4a", pc4, 32'd4);
    stall4 = 1'b1;
    step();
    chk("m4_pc4b", pc4, 32'd4);
    step();
    chk("m4_pc4c", pc4, 32'd4);
    stall4 = 1'b0;
    step();
    chk("m4_pc8", pc4, 32'd8);
    step();
    chk("m4_pc12", pc4, 32'd12);
    chk("m4_valid12", {31'b0, valid4}, 32'd1);
    chk("m4_instr12", instr4, I_ADDI);
    step();
    chk("m4_halted", {31'b0, halted4}, 32'd1);
    chk("m4_pc_nowrap", pc4, 32'd12);
    chk("m4_ret", {29'b0, ret4}, 32'd4);
    chk("m4_cyc", {29'b0, cyc4}, 32'd6);
    step();
    chk("m4_pc_hold", pc4, 32'd12);

    // 4-word memory, no stall
    rst4 = 1'b1;
    step();
    rst4 = 1'b0;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    step(); step(); step();
    chk("m4b_pc12", pc4, 32'd12);
    step();
    chk("m4b_halted", {31'b0, halted4}, 32'd1);
    chk("m4b_pc", pc4, 32'd12);
    chk("m4b_ret", {29'b0, ret4}, 32'd4);
    chk("m4b_cyc", {29'b0, cyc4}, 32'd4);

    // 3-bit cycle counter saturates during a long stall
    rst4 = 1'b1;
    step();
    rst4 = 1'b0;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    stall4 = 1'b1;
    for (int i = 0; i < 9; i++) step();
    stall4 = 1'b0;
    chk("sat_cyc", {29'b0, cyc4}, 32'd7);
    chk("sat_ret", {29'b0, ret4}, 32'd0);
    chk("sat_pc", pc4, 32'd0);
    step(); step(); step(); step();
    chk("sat_halted", {31'b0, halted4}, 32'd1);
    chk("sat_cyc_end", {29'b0, cyc4}, 32'd7);
    chk("sat_ret_end", {29'b0, ret4}, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
